// File: rtl/load_scoreboard.sv
// -----------------------------------------------------------------------------
// load_scoreboard
// Decode-stage scoreboard and stall controller for a variable-latency data
// memory. It keeps one busy bit per architectural register with a load in
// flight. It stalls the instruction in ID on a RAW or WAW hazard against those
// registers, or when the outstanding-load budget is already used up. It drives
// the bubble controls into IF and ID.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous reset, active low
//   id_valid      in   ID holds a valid instruction
//   id_rs1/rs2    in   ID source registers
//   id_use_rs1/2  in   instruction reads rs1 / rs2
//   id_rd         in   ID destination register
//   id_regwrite   in   instruction writes rd
//   id_memread    in   instruction is a load
//   ld_done       in   load data returns this cycle (forwardable this cycle)
//   ld_rd         in   destination register of the returning load
//   pcwrite       out  1 = PC may advance
//   ifidwrite     out  1 = IF/ID register may load
//   clearcontrol  out  1 = zero ID control signals (bubble)
//   outst_cnt     out  number of loads in flight
//   stall_cycles  out  saturating count of stalled cycles
//   err_spurious  out  sticky: ld_done arrived for a register that was not busy
// -----------------------------------------------------------------------------
module load_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int MAX_OUTST = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [4:0]           id_rd,
  input  logic                 id_regwrite,
  input  logic                 id_memread,
  input  logic                 ld_done,
  input  logic [4:0]           ld_rd,
  output logic                 pcwrite,
  output logic                 ifidwrite,
  output logic                 clearcontrol,
  output logic [2:0]           outst_cnt,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic                 err_spurious
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTST);

  // State
  logic [NUM_REGS-1:0]  r_busy;
  logic [2:0]           r_outst_cnt;
  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic                 r_err_spurious;

  // Combinational decode
  logic [NUM_REGS-1:0]  w_ebusy;
  logic                 w_valid_retire;
  logic [2:0]           w_cnt_after_retire;
  logic                 w_raw;
  logic                 w_waw;
  logic                 w_full;
  logic                 w_stall;
  logic                 w_issue;

  // Next state
  logic [NUM_REGS-1:0]  w_busy_nxt;
  logic [2:0]           w_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_stall_cycles_nxt;
  logic                 w_err_nxt;

  // Effective busy: a load returning this cycle is forwarded, so its
  // dependents see the register as free right away. x0 is never busy.
  always_comb begin
    w_ebusy = r_busy;
    if (ld_done) begin
      w_ebusy[ld_rd] = 1'b0;
    end else begin
      w_ebusy = r_busy;
    end
    w_ebusy[0] = 1'b0;
  end

  // Hazard detection and issue qualification
  always_comb begin
    w_valid_retire     = ld_done & r_busy[ld_rd] & (ld_rd != 5'd0);
    // A retirement in the same cycle frees one budget slot for the load in ID.
    w_cnt_after_retire = r_outst_cnt - {2'b00, w_valid_retire};
    w_raw   = (id_use_rs1 & w_ebusy[id_rs1]) | (id_use_rs2 & w_ebusy[id_rs2]);
    w_waw   = id_regwrite & w_ebusy[id_rd];
    w_full  = id_memread & (w_cnt_after_retire == MAX_CNT);
    w_stall = id_valid & (w_raw | w_waw | w_full);
    w_issue = id_valid & ~w_stall & id_memread & id_regwrite & (id_rd != 5'd0);
  end

  // Next-state computation for busy bits, budget counter, stall counter, error
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_valid_retire) begin
      w_busy_nxt[ld_rd] = 1'b0;
    end else begin
      w_busy_nxt = r_busy;
    end
    // Applied after the clear so a same-register issue/retire keeps the bit set.
    if (w_issue) begin
      w_busy_nxt[id_rd] = 1'b1;
    end else begin
      w_busy_nxt[0] = 1'b0;
    end
    w_busy_nxt[0] = 1'b0;

    // Clamped so a corrupted input history can never wrap the counter.
    case ({w_issue, w_valid_retire})
      2'b10: begin
        if (r_outst_cnt != MAX_CNT) begin
          w_cnt_nxt = r_outst_cnt + 3'd1;
        end else begin
          w_cnt_nxt = r_outst_cnt;
        end
      end
      2'b01: begin
        if (r_outst_cnt != 3'd0) begin
          w_cnt_nxt = r_outst_cnt - 3'd1;
        end else begin
          w_cnt_nxt = r_outst_cnt;
        end
      end
      default: w_cnt_nxt = r_outst_cnt;
    endcase

    if (w_stall && (r_stall_cycles != {CNT_WIDTH{1'b1}})) begin
      w_stall_cycles_nxt = r_stall_cycles + CNT_WIDTH'(1);
    end else begin
      w_stall_cycles_nxt = r_stall_cycles;
    end

    if (ld_done && !w_valid_retire) begin
      w_err_nxt = 1'b1;
    end else begin
      w_err_nxt = r_err_spurious;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy         <= {NUM_REGS{1'b0}};
      r_outst_cnt    <= 3'd0;
      r_stall_cycles <= {CNT_WIDTH{1'b0}};
      r_err_spurious <= 1'b0;
    end else begin
      r_busy         <= w_busy_nxt;
      r_outst_cnt    <= w_cnt_nxt;
      r_stall_cycles <= w_stall_cycles_nxt;
      r_err_spurious <= w_err_nxt;
    end
  end

  // Bubble controls are combinational so the stall takes effect this cycle.
  always_comb begin
    pcwrite      = ~w_stall;
    ifidwrite    = ~w_stall;
    clearcontrol = w_stall;
    outst_cnt    = r_outst_cnt;
    stall_cycles = r_stall_cycles;
    err_spurious = r_err_spurious;
  end

endmodule

// File: tb/tb_load_scoreboard.sv
module tb_load_scoreboard;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        ld_done;
  logic [4:0]  ld_rd;
  logic        pcwrite;
  logic        ifidwrite;
  logic        clearcontrol;
  logic [2:0]  outst_cnt;
  logic [15:0] stall_cycles;
  logic        err_spurious;

  // Second instance with a 3-bit stall counter to reach saturation quickly
  logic        s_pcwrite;
  logic        s_ifidwrite;
  logic        s_clearcontrol;
  logic [2:0]  s_outst_cnt;
  logic [2:0]  s_stall_cycles;
  logic        s_err_spurious;

  load_scoreboard u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ld_done(ld_done),
    .ld_rd(ld_rd), .pcwrite(pcwrite), .ifidwrite(ifidwrite),
    .clearcontrol(clearcontrol), .outst_cnt(outst_cnt),
    .stall_cycles(stall_cycles), .err_spurious(err_spurious)
  );

  load_scoreboard #(.CNT_WIDTH(3)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ld_done(ld_done),
    .ld_rd(ld_rd), .pcwrite(s_pcwrite), .ifidwrite(s_ifidwrite),
    .clearcontrol(s_clearcontrol), .outst_cnt(s_outst_cnt),
    .stall_cycles(s_stall_cycles), .err_spurious(s_err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        ld;
    logic [4:0]  ldrd;
    logic        chk;
    logic        stall;
    logic [2:0]  cnt;
    logic [15:0] sc;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, input logic vld,
                              input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2,
                              input logic [4:0] rd, input logic rw, input logic mr,
                              input logic ld, input logic [4:0] ldrd,
                              input logic chk, input logic stall,
                              input logic [2:0] cnt, input logic [15:0] sc,
                              input logic err);
    vec_t v;
    v.rst = r; v.vld = vld; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.rd = rd; v.rw = rw; v.mr = mr; v.ld = ld; v.ldrd = ldrd; v.chk = chk;
    v.stall = stall; v.cnt = cnt; v.sc = sc; v.err = err;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare at the falling edge
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    logic [15:0] sat;
    @(posedge clk);
    #1;
    rst = v.rst; id_valid = v.vld; id_rs1 = v.rs1; id_use_rs1 = v.u1;
    id_rs2 = v.rs2; id_use_rs2 = v.u2; id_rd = v.rd; id_regwrite = v.rw;
    id_memread = v.mr; ld_done = v.ld; ld_rd = v.ldrd;
    if (v.chk) sb.push_back(v);
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      sat = (e.sc > 16'd7) ? 16'd7 : e.sc;
      check({tag, " ctl"}, {29'd0, pcwrite, ifidwrite, clearcontrol},
            {29'd0, ~e.stall, ~e.stall, e.stall});
      check({tag, " outst_cnt"}, {29'd0, outst_cnt}, {29'd0, e.cnt});
      check({tag, " stall_cycles"}, {16'd0, stall_cycles}, {16'd0, e.sc});
      check({tag, " err_spurious"}, {31'd0, err_spurious}, {31'd0, e.err});
      check({tag, " sat_stall_cycles"}, {29'd0, s_stall_cycles}, {16'd0, sat});
    end
  endtask

  int exp_sc;

  // Load x12, hold a dependent for n cycles, then return the load
  task automatic lat_seq(input int n);
    step(mk(1, 1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 1, 0, 0, 16'(exp_sc), 1), "lat_issue");
    for (int k = 0; k < n; k++) begin
      step(mk(1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 16'(exp_sc + k), 1), "lat_wait");
    end
    step(mk(1, 1, 12, 1, 0, 0, 0, 0, 0, 1, 12, 1, 0, 1, 16'(exp_sc + n), 1), "lat_done");
    exp_sc = exp_sc + n;
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'(exp_sc), 1), "lat_idle");
  endtask

  initial begin
    rst = 1'b0; id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rd = 5'd0; id_regwrite = 1'b0;
    id_memread = 1'b0; ld_done = 1'b0; ld_rd = 5'd0;

    //             rst vld rs1 u1 rs2 u2 rd rw mr ld ldrd chk st cnt sc err
    // Reset
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // RAW on x5
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 0));
    vecs.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 1, 5, 1, 0, 1, 3, 0));
    vecs.push_back(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0));
    // WAW on x7
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 1, 0, 0, 3, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 7, 1, 0, 0, 0, 1, 1, 1, 3, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 7, 1, 0, 0, 0, 1, 1, 1, 4, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 7, 1, 0, 1, 7, 1, 0, 1, 5, 0));
    // Load to x0 is ignored
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 5, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 0));
    // Budget: four loads, fifth stalls until x2 returns
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 5, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 1, 0, 1, 5, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 1, 0, 2, 5, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 1, 0, 3, 5, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 1, 1, 4, 5, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 1, 1, 4, 6, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 9, 1, 1, 1, 2, 1, 0, 4, 7, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 7, 0));
    // Same-register issue and retire on x3
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 3, 1, 1, 1, 3, 1, 0, 4, 7, 0));
    vecs.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 7, 0));
    // Drain x1, x3, x4, x9
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 4, 8, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 3, 8, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 2, 8, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 0, 1, 8, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8, 0));
    // rs2 hazard, use-bit masking, id_valid masking
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 1, 0, 0, 8, 0));
    vecs.push_back(mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 8, 0));
    vecs.push_back(mk(1, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, 1, 1, 8, 0));
    vecs.push_back(mk(1, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, 0, 1, 9, 0));
    // Reset mid-flight, then a late return of x6 is spurious
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    exp_sc = 0;
    lat_seq(1);
    lat_seq(int'($urandom_range(6, 2)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
